uart_status_tx: RTL and testbench

- UART 8N1 transmitter that serialises a fixed 4-byte game-status packet onto RsTx.
- Counterpart to the receive side of uart_echo. Clocked from the 25 MHz pixel clock alongside the sprite and timer blocks.
- Game logic pulses `send`. The block latches state and hp and frames them as header, state, hp, checksum.
- The host-side tool decodes the packet.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_tx_byte.sv | 132 +++++++++++++
 rtl/uart_status_tx.sv | 122 ++++++++++++
 tb/tb_uart_status_tx.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared definitions for the UART blocks: serialiser FSM states,
//            status-packet header byte, packet length and packet checksum.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Bit-level 8N1 framing states.
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_fsm_e;

    // First byte of every status packet; the host resynchronises on it.
    localparam logic [7:0] PKT_HEADER = 8'hA5;

    // Header, state, hp, checksum.
    localparam int PKT_BYTES = 4;

    // XOR checksum over the three payload-carrying bytes.
    function automatic logic [7:0] pkt_checksum(
        input logic [7:0] hdr,
        input logic [7:0] b1,
        input logic [7:0] b2
    );
        return hdr ^ b1 ^ b2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_byte
// Purpose  : Bit-level 8N1 serialiser. One start bit, eight data bits LSB
//            first, one stop bit, each held CLKS_PER_BIT cycles.
// Ports    : Pclk    - clock, rising edge
//            RESET   - synchronous active-high reset
//            load    - start a byte (accepted in IDLE, or in the last cycle
//                      of a stop bit for gap-free back-to-back bytes)
//            data    - byte to send, sampled when load is accepted
//            TX      - registered serial output, idle high
//            tx_done - high during the final cycle of the stop bit
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 2604
) (
    input  logic       Pclk,
    input  logic       RESET,
    input  logic       load,
    input  logic [7:0] data,
    output logic       TX,
    output logic       tx_done
);

    localparam int                  c_cnt_w     = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0]  c_baud_last = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0]  c_baud_one  = c_cnt_w'(1);

    tx_fsm_e              r_fsm_q,   w_fsm_d;
    logic [c_cnt_w-1:0]   r_baud_q,  w_baud_d;
    logic [2:0]           r_bit_q,   w_bit_d;
    logic [7:0]           r_shift_q, w_shift_d;
    logic                 r_tx_q,    w_tx_d;
    logic                 w_last;

    assign w_last  = (r_baud_q == c_baud_last);
    assign TX      = r_tx_q;
    // Decoded from registered state so the sequencer can issue the next load
    // in the same cycle and the next start bit follows with no idle gap.
    assign tx_done = (r_fsm_q == TX_STOP) && w_last;

    always_comb begin
        w_fsm_d   = r_fsm_q;
        w_baud_d  = r_baud_q;
        w_bit_d   = r_bit_q;
        w_shift_d = r_shift_q;
        w_tx_d    = r_tx_q;

        case (r_fsm_q)
            TX_IDLE: begin
                w_baud_d = '0;
                if (load) begin
                    w_fsm_d   = TX_START;
                    w_shift_d = data;
                    w_bit_d   = '0;
                    w_tx_d    = 1'b0;
                end
            end

            TX_START: begin
                if (w_last) begin
                    w_baud_d = '0;
                    w_fsm_d  = TX_DATA;
                    w_bit_d  = '0;
                    w_tx_d   = r_shift_q[0];
                end else begin
                    w_baud_d = r_baud_q + c_baud_one;
                end
            end

            TX_DATA: begin
                if (w_last) begin
                    w_baud_d  = '0;
                    w_shift_d = {1'b0, r_shift_q[7:1]};
                    if (r_bit_q == 3'd7) begin
                        w_fsm_d = TX_STOP;
                        w_tx_d  = 1'b1;
                    end else begin
                        w_bit_d = r_bit_q + 3'd1;
                        // Next bit is the one about to land in position 0.
                        w_tx_d  = r_shift_q[1];
                    end
                end else begin
                    w_baud_d = r_baud_q + c_baud_one;
                end
            end

            TX_STOP: begin
                if (w_last) begin
                    w_baud_d = '0;
                    if (load) begin
                        w_fsm_d   = TX_START;
                        w_shift_d = data;
                        w_bit_d   = '0;
                        w_tx_d    = 1'b0;
                    end else begin
                        w_fsm_d = TX_IDLE;
                        w_tx_d  = 1'b1;
                    end
                end else begin
                    w_baud_d = r_baud_q + c_baud_one;
                end
            end

            default: begin
                w_fsm_d = TX_IDLE;
                w_tx_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Pclk) begin
        if (RESET) begin
            r_fsm_q   <= TX_IDLE;
            r_baud_q  <= '0;
            r_bit_q   <= '0;
            r_shift_q <= '0;
            r_tx_q    <= 1'b1;
        end else begin
            r_fsm_q   <= w_fsm_d;
            r_baud_q  <= w_baud_d;
            r_bit_q   <= w_bit_d;
            r_shift_q <= w_shift_d;
            r_tx_q    <= w_tx_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_status_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_status_tx
// Purpose  : Sends a 4-byte game-status packet (header, state, hp, checksum)
//            as 8N1 UART on TX each time send is accepted.
// Ports    : Pclk  - pixel clock, rising edge
//            RESET - synchronous active-high reset
//            send  - request a packet; ignored while busy and in the done cycle
//            state - 3-bit game state, latched on acceptance
//            hp    - 8-bit player HP, latched on acceptance
//            TX    - serial line, idle high
//            busy  - packet in flight
//            done  - one-cycle pulse after the final stop bit
// Revision : 1.0  initial release
// ============================================================================
module uart_status_tx
    import uart_pkg::*;
#(
    parameter int         CLK_HZ       = 25000000,
    parameter int         BAUD         = 9600,
    parameter int         CLKS_PER_BIT = CLK_HZ / BAUD,
    parameter logic [7:0] HEADER       = PKT_HEADER
) (
    input  logic       Pclk,
    input  logic       RESET,
    input  logic       send,
    input  logic [2:0] state,
    input  logic [7:0] hp,
    output logic       TX,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] c_last_idx = 2'(PKT_BYTES - 1);

    logic       r_busy_q, w_busy_d;
    logic       r_done_q, w_done_d;
    logic [1:0] r_idx_q,  w_idx_d;
    logic [7:0] r_b1_q,   w_b1_d;
    logic [7:0] r_b2_q,   w_b2_d;
    logic [7:0] r_ck_q,   w_ck_d;

    logic       w_load;
    logic [7:0] w_load_data;
    logic       w_byte_done;
    logic [7:0] w_state_byte;

    assign w_state_byte = {5'b0, state};

    always_comb begin
        w_busy_d    = r_busy_q;
        w_done_d    = 1'b0;
        w_idx_d     = r_idx_q;
        w_b1_d      = r_b1_q;
        w_b2_d      = r_b2_q;
        w_ck_d      = r_ck_q;
        w_load      = 1'b0;
        w_load_data = HEADER;

        if (!r_busy_q) begin
            // The done cycle is not an acceptance slot; the earliest re-send
            // is sampled on the edge after done.
            if (send && !r_done_q) begin
                w_busy_d    = 1'b1;
                w_idx_d     = '0;
                w_b1_d      = w_state_byte;
                w_b2_d      = hp;
                w_ck_d      = pkt_checksum(HEADER, w_state_byte, hp);
                w_load      = 1'b1;
                w_load_data = HEADER;
            end
        end else if (w_byte_done) begin
            if (r_idx_q == c_last_idx) begin
                w_busy_d = 1'b0;
                w_done_d = 1'b1;
                w_idx_d  = '0;
            end else begin
                w_idx_d = r_idx_q + 2'd1;
                w_load  = 1'b1;
                case (r_idx_q)
                    2'd0:    w_load_data = r_b1_q;
                    2'd1:    w_load_data = r_b2_q;
                    default: w_load_data = r_ck_q;
                endcase
            end
        end
    end

    always_ff @(posedge Pclk) begin
        if (RESET) begin
            r_busy_q <= 1'b0;
            r_done_q <= 1'b0;
            r_idx_q  <= '0;
            r_b1_q   <= '0;
            r_b2_q   <= '0;
            r_ck_q   <= '0;
        end else begin
            r_busy_q <= w_busy_d;
            r_done_q <= w_done_d;
            r_idx_q  <= w_idx_d;
            r_b1_q   <= w_b1_d;
            r_b2_q   <= w_b2_d;
            r_ck_q   <= w_ck_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx_byte (
        .Pclk    (Pclk),
        .RESET   (RESET),
        .load    (w_load),
        .data    (w_load_data),
        .TX      (TX),
        .tx_done (w_byte_done)
    );

    assign busy = r_busy_q;
    assign done = r_done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_status_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_status_tx
// Purpose  : Scoreboard bench for uart_status_tx. A packet-level model queues
//            expected bytes (with start cycles) and done cycles; independent
//            monitors decode TX and watch done, popping and comparing.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_status_tx;

    localparam int CPB     = 4;
    localparam int PKT_CYC = 40 * CPB;

    logic       Pclk = 1'b0;
    logic       RESET;
    logic       send;
    logic [2:0] state_i;
    logic [7:0] hp_i;
    logic       TX, busy, done;

    logic       send2;
    logic [2:0] state2;
    logic [7:0] hp2;
    logic       tx2, busy2, done2;

    always #5 Pclk = ~Pclk;

    uart_status_tx #(.CLKS_PER_BIT(CPB)) dut (
        .Pclk(Pclk), .RESET(RESET), .send(send), .state(state_i), .hp(hp_i),
        .TX(TX), .busy(busy), .done(done)
    );

    uart_status_tx dut_dflt (
        .Pclk(Pclk), .RESET(RESET), .send(send2), .state(state2), .hp(hp2),
        .TX(tx2), .busy(busy2), .done(done2)
    );

    typedef struct {
        logic [7:0] data;
        int         start;
    } exp_byte_t;

    exp_byte_t exp_q[$];
    int        done_q[$];
    int        cyc       = 0;
    int        free_edge = 0;
    int        rst_gen   = 0;
    int        n_vec     = 0;
    int        n_err     = 0;

    always @(posedge Pclk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Packet model: contents and timing from the packet rules alone.
    task automatic model_send(input int k, input logic [2:0] st, input logic [7:0] h);
        logic [7:0] pkt[4];
        exp_byte_t  e;
        pkt[0] = 8'hA5;
        pkt[1] = {5'b0, st};
        pkt[2] = h;
        pkt[3] = pkt[0] ^ pkt[1] ^ pkt[2];
        for (int i = 0; i < 4; i++) begin
            e.data  = pkt[i];
            e.start = k + i * 10 * CPB;
            exp_q.push_back(e);
        end
        done_q.push_back(k + PKT_CYC);
        // Busy until done; the done cycle itself cannot accept.
        free_edge = k + PKT_CYC + 2;
    endtask

    // Drive one cycle of inputs; they are sampled on edge cyc+1.
    task automatic tick(input logic s, input logic [2:0] st, input logic [7:0] h);
        int k;
        send    = s;
        state_i = st;
        hp_i    = h;
        k = cyc + 1;
        if (s && k >= free_edge) model_send(k, st, h);
        @(posedge Pclk); #1;
    endtask

    task automatic do_reset(input logic s);
        int k;
        RESET   = 1'b1;
        send    = s;
        state_i = 3'($urandom);
        hp_i    = 8'($urandom);
        k = cyc + 1;
        rst_gen++;
        exp_q.delete();
        done_q.delete();
        free_edge = k + 1;
        @(posedge Pclk); #1;
        check("rst_tx", TX, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        RESET = 1'b0;
        send  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0) && n < 20 * PKT_CYC) begin
            tick(1'b0, 3'($urandom), 8'($urandom));
            n++;
        end
        n_vec++;
        if (exp_q.size() != 0 || done_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: %0d bytes, %0d done pulses outstanding, expected 0",
                     exp_q.size(), done_q.size());
        end
        tick(1'b0, 3'd0, 8'd0);
        tick(1'b0, 3'd0, 8'd0);
    endtask

    // TX decoder: every bit must hold CPB samples; busy must stay high.
    initial begin : rx_mon
        int          gen, f;
        logic [9:0]  bits;
        bit          wide_ok, busy_ok, aborted;
        exp_byte_t   e;
        forever begin
            @(negedge Pclk);
            if (TX === 1'b0) begin
                gen = rst_gen; f = cyc; bits = '0;
                wide_ok = 1'b1; busy_ok = 1'b1; aborted = 1'b0;
                for (int b = 0; b < 10 && !aborted; b++) begin
                    for (int s = 0; s < CPB && !aborted; s++) begin
                        if (b != 0 || s != 0) @(negedge Pclk);
                        if (rst_gen != gen) aborted = 1'b1;
                        else begin
                            if (s == 0) bits[b] = TX;
                            else if (TX !== bits[b]) wide_ok = 1'b0;
                            if (busy !== 1'b1) busy_ok = 1'b0;
                        end
                    end
                end
                if (!aborted) begin
                    if (exp_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL rx_unexpected: got byte %02h at cycle %0d, expected none",
                                 bits[8:1], f);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_byte", bits[8:1], e.data);
                        check("rx_start_cycle", f, e.start);
                        check("rx_framing", {bits[9], bits[0]}, 2'b10);
                        check("rx_bit_width", wide_ok, 1);
                        check("rx_busy", busy_ok, 1);
                    end
                end
            end
        end
    end

    initial begin : done_mon
        int e;
        forever begin
            @(negedge Pclk);
            if (done === 1'b1) begin
                if (done_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL done_unexpected: got done at cycle %0d, expected none", cyc);
                end else begin
                    e = done_q.pop_front();
                    check("done_cycle", cyc, e);
                end
                check("busy_at_done", busy, 0);
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int k, f, w, n;
        RESET = 1'b1; send = 1'b0; state_i = '0; hp_i = '0;
        send2 = 1'b0; state2 = '0; hp2 = '0;
        @(posedge Pclk); #1;
        do_reset(1'b0);

        // Basic packet: A5 02 64 C3.
        tick(1'b1, 3'd2, 8'd100);
        drain();

        // Inputs move every cycle after acceptance.
        tick(1'b1, 3'd2, 8'd100);
        for (int i = 0; i < PKT_CYC + 4; i++)
            tick(1'b0, (i % 2) ? 3'd7 : 3'd0, (i % 2) ? 8'd0 : 8'd255);
        drain();

        // send during a packet at cycles 20 and 100 is dropped.
        tick(1'b1, 3'd2, 8'd100);
        for (int i = 1; i <= PKT_CYC + 1; i++)
            tick((i == 20) || (i == 100), 3'd7, 8'h55);
        drain();

        // Back-to-back: send in done cycle ignored, next cycle accepted.
        tick(1'b1, 3'd2, 8'd100);
        n = 0;
        while (done !== 1'b1 && n < 2 * PKT_CYC) begin
            tick(1'b0, 3'd0, 8'd0);
            n++;
        end
        check("b2b_done_seen", done, 1);
        tick(1'b1, 3'd5, 8'd9);
        check("b2b_ignored_busy", busy, 0);
        tick(1'b1, 3'd0, 8'd0);
        check("b2b_accept_busy", busy, 1);
        send = 1'b0;
        drain();

        // Reset in byte1 bit3: TX forced high, no done, then a clean packet.
        tick(1'b1, 3'd2, 8'd100);
        for (int i = 0; i < 56; i++) tick(1'b0, 3'd2, 8'd100);
        do_reset(1'b0);
        for (int i = 0; i < 3 * PKT_CYC; i++) tick(1'b0, 3'd0, 8'd0);
        tick(1'b1, 3'($urandom), 8'($urandom));
        drain();

        // Reset and send together: reset wins.
        do_reset(1'b1);
        for (int i = 0; i < 2 * CPB; i++) tick(1'b0, 3'd0, 8'd0);

        // Random traffic, inputs changing every cycle.
        for (int i = 0; i < 3000; i++)
            tick($urandom_range(0, 29) == 0, 3'($urandom), 8'($urandom));
        drain();

        // Default divider: start bit lasts 2604 cycles, latency one edge.
        send2 = 1'b1; state2 = 3'd1; hp2 = 8'd1;
        k = cyc + 1;
        @(posedge Pclk); #1;
        send2 = 1'b0;
        n = 0;
        while (tx2 !== 1'b0 && n < 8) begin
            @(posedge Pclk); #1;
            n++;
        end
        f = cyc;
        check("dflt_latency", f, k);
        w = 0;
        while (tx2 === 1'b0 && w < 3000) begin
            w++;
            @(posedge Pclk); #1;
        end
        check("dflt_bit_width", w, 2604);

        check("final_bytes_left", exp_q.size(), 0);
        check("final_done_left", done_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
